// File: rtl/router_pkg.sv
// Shared constants for the 1x3 router: byte width, header field layout and FIFO sizing.
// Any block that decodes a header byte imports this package.
package router_pkg;

    localparam int ROUTER_DATA_W     = 8;
    localparam int ROUTER_LEN_W      = 6;
    localparam int ROUTER_FIFO_DEPTH = 16;

    localparam int LEN_MSB  = 7;
    localparam int LEN_LSB  = 2;
    localparam int ADDR_MSB = 1;
    localparam int ADDR_LSB = 0;

    function automatic logic [ROUTER_LEN_W-1:0] headerLen(input logic [ROUTER_DATA_W-1:0] hdr);
        return hdr[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// Dual-port storage for router_fifo: synchronous write, registered payload read,
// plus a combinational view of the head entry so the owner can decode it before the read edge.
module router_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr_i,
    input  logic              wrEn_i,
    input  logic [ADDR_W-1:0] wrAddr_i,
    input  logic [DATA_W:0]   wrData_i,
    input  logic              rdEn_i,
    input  logic [ADDR_W-1:0] rdAddr_i,
    output logic [DATA_W-1:0] rdData_o,
    output logic [DATA_W:0]   peek_o
);

    logic [DATA_W:0]   memArray [DEPTH];
    logic [DATA_W-1:0] rdData_q;

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            memArray[wrAddr_i] <= wrData_i;
        end
    end

    // Only the read register is cleared; stale array contents are never visible
    // because the pointers are flushed at the same time.
    always_ff @(posedge clk) begin
        if (clr_i) begin
            rdData_q <= '0;
        end else if (rdEn_i) begin
            rdData_q <= memArray[rdAddr_i][DATA_W-1:0];
        end
    end

    assign rdData_o = rdData_q;
    assign peek_o   = memArray[rdAddr_i];

endmodule

// File: rtl/router_fifo.sv
// Per-destination output FIFO of the 1x3 router: tags header bytes on write and
// counts each packet down on read so the last (parity) byte raises pkt_done.
module router_fifo
    import router_pkg::*;
#(
    parameter int DEPTH  = ROUTER_FIFO_DEPTH,
    parameter int DATA_W = ROUTER_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              soft_reset,
    input  logic              write_enb,
    input  logic              read_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              pkt_done
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    // One extra bit so a maximum-length payload plus its parity byte still fits.
    localparam int CNT_W  = ROUTER_LEN_W + 1;

    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] pktCnt_q, pktCnt_d;
    logic             pktDone_q, pktDone_d;
    logic             flush, doWrite, doRead;
    logic [DATA_W:0]  headEntry;

    assign flush   = reset || soft_reset;
    assign empty   = (wrPtr_q == rdPtr_q);
    assign full    = (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]) &&
                     (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]);
    assign doWrite = write_enb && !full && !flush;
    assign doRead  = read_enb && !empty;

    router_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk      (clk),
        .clr_i    (flush),
        .wrEn_i   (doWrite),
        .wrAddr_i (wrPtr_q[ADDR_W-1:0]),
        .wrData_i ({lfd_state, data_in}),
        .rdEn_i   (doRead),
        .rdAddr_i (rdPtr_q[ADDR_W-1:0]),
        .rdData_o (data_out),
        .peek_o   (headEntry)
    );

    always_comb begin
        wrPtr_d   = wrPtr_q;
        rdPtr_d   = rdPtr_q;
        pktCnt_d  = pktCnt_q;
        pktDone_d = 1'b0;
        if (doWrite) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (doRead) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
            // A header always reloads, abandoning any packet still in progress.
            if (headEntry[DATA_W]) begin
                pktCnt_d = {1'b0, headerLen(headEntry[DATA_W-1:0])} + CNT_W'(1);
            end else if (pktCnt_q != '0) begin
                pktCnt_d  = pktCnt_q - CNT_W'(1);
                pktDone_d = (pktCnt_q == CNT_W'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wrPtr_q   <= '0;
            rdPtr_q   <= '0;
            pktCnt_q  <= '0;
            pktDone_q <= 1'b0;
        end else begin
            wrPtr_q   <= wrPtr_d;
            rdPtr_q   <= rdPtr_d;
            pktCnt_q  <= pktCnt_d;
            pktDone_q <= pktDone_d;
        end
    end

    assign pkt_done = pktDone_q;

endmodule
